// File: rtl/cnt_pkg.sv
// Shared definitions for the modulo up/down counter family.
package cnt_pkg;

  // Bound behaviour selectors for the SATURATE parameter.
  localparam int unsigned CNT_WRAP = 0;
  localparam int unsigned CNT_SAT  = 1;

  // Per-edge operation after priority resolution.
  typedef enum logic [1:0] {
    OpHold,
    OpLoad,
    OpUp,
    OpDown
  } cnt_op_e;

  // Clamp a value into 0..max_value; callers narrow the result to their width.
  function automatic logic [31:0] clamp_to_max(input logic [31:0] value,
                                               input logic [31:0] max_value);
    return (value > max_value) ? max_value : value;
  endfunction

endpackage

// File: rtl/mod_updown_counter_if.sv
// Control/status bundle of the modulo up/down counter.
interface mod_updown_counter_if #(
  parameter int unsigned WIDTH = 12
) ();

  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             en;
  logic             up;
  logic             clr_flags;
  logic [WIDTH-1:0] cmp_value;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             match;
  logic             ovf;
  logic             udf;

  // Controller side: drives the strobes, observes the counter.
  modport master (
    output load, load_value, en, up, clr_flags, cmp_value,
    input  count, tc, match, ovf, udf
  );

  // Counter side.
  modport slave (
    input  load, load_value, en, up, clr_flags, cmp_value,
    output count, tc, match, ovf, udf
  );

endinterface

// File: rtl/mod_updown_counter_sticky_flag.sv
// Sticky status bit: set wins over clear, async active-high reset.
module sticky_flag (
  input  logic clk,
  input  logic rst,
  input  logic set_i,
  input  logic clr_i,
  output logic q_o
);

  logic flag_q, flag_d;

  // Next state: set dominates a simultaneous clear.
  always_comb begin
    flag_d = flag_q;
    if (set_i) begin
      flag_d = 1'b1;
    end else if (clr_i) begin
      flag_d = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_q <= 1'b0;
    end else begin
      flag_q <= flag_d;
    end
  end

  assign q_o = flag_q;

endmodule

// File: rtl/mod_updown_counter.sv
// Modulo up/down counter with load, registered terminal-count pulse,
// sticky overflow/underflow flags and compare match.
module mod_updown_counter
  import cnt_pkg::*;
#(
  parameter int unsigned WIDTH     = 12,
  parameter int unsigned MAX_COUNT = 4095,
  parameter int unsigned SATURATE  = CNT_WRAP
) (
  input logic                  clk,
  input logic                  rst,
  mod_updown_counter_if.slave  bus_io
);

  if ((WIDTH < 2) || (WIDTH > 32)) begin : g_width_check
    $error("mod_updown_counter: WIDTH must be in 2..32");
  end
  if (64'(MAX_COUNT) >= (64'd1 << WIDTH)) begin : g_max_check
    $error("mod_updown_counter: MAX_COUNT must be below 2**WIDTH");
  end

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX_COUNT);
  localparam bit               Sat    = (SATURATE == CNT_SAT);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_set, udf_set;
  cnt_op_e          op;

  // Resolve load > enable priority and direction into one operation.
  always_comb begin
    op = OpHold;
    if (bus_io.load) begin
      op = OpLoad;
    end else if (bus_io.en) begin
      op = bus_io.up ? OpUp : OpDown;
    end
  end

  // Next count, terminal-count pulse and flag set requests.
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    ovf_set = 1'b0;
    udf_set = 1'b0;
    unique case (op)
      OpLoad: begin
        count_d = WIDTH'(clamp_to_max(32'(bus_io.load_value), 32'(MAX_COUNT)));
      end
      OpUp: begin
        // Explicit bound compare so non-power-of-2 moduli wrap correctly.
        if (count_q == MaxVal) begin
          tc_d    = 1'b1;
          ovf_set = 1'b1;
          count_d = Sat ? MaxVal : '0;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      OpDown: begin
        if (count_q == '0) begin
          tc_d    = 1'b1;
          udf_set = 1'b1;
          count_d = Sat ? '0 : MaxVal;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
      default: begin
        count_d = count_q;
      end
    endcase
  end

  // Count and terminal-count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  sticky_flag u_ovf (
    .clk   (clk),
    .rst   (rst),
    .set_i (ovf_set),
    .clr_i (bus_io.clr_flags),
    .q_o   (bus_io.ovf)
  );

  sticky_flag u_udf (
    .clk   (clk),
    .rst   (rst),
    .set_i (udf_set),
    .clr_i (bus_io.clr_flags),
    .q_o   (bus_io.udf)
  );

  assign bus_io.count = count_q;
  assign bus_io.tc    = tc_q;
  assign bus_io.match = (count_q == bus_io.cmp_value);

endmodule

// File: tb/tb_mod_updown_counter.sv
// Self-checking bench: three counter configurations share one stimulus stream
// and are compared every cycle against an arithmetic reference model.
module tb_mod_updown_counter;

  localparam int NI = 3;
  // Instance 0: 12-bit full range wrap; 1: MAX=9 wrap; 2: MAX=9 saturate.
  localparam int MAXS [NI] = '{4095, 9, 9};
  localparam bit SATS [NI] = '{1'b0, 1'b0, 1'b1};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mod_updown_counter_if #(.WIDTH(12)) bus_a ();
  mod_updown_counter_if #(.WIDTH(12)) bus_b ();
  mod_updown_counter_if #(.WIDTH(12)) bus_c ();

  mod_updown_counter #(.WIDTH(12), .MAX_COUNT(4095), .SATURATE(0)) u_a (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus_a)
  );
  mod_updown_counter #(.WIDTH(12), .MAX_COUNT(9), .SATURATE(0)) u_b (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus_b)
  );
  mod_updown_counter #(.WIDTH(12), .MAX_COUNT(9), .SATURATE(1)) u_c (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus_c)
  );

  logic [11:0] d_cnt [NI];
  logic        d_tc  [NI];
  logic        d_ovf [NI];
  logic        d_udf [NI];
  logic        d_mat [NI];
  assign d_cnt[0] = bus_a.count;  assign d_cnt[1] = bus_b.count;  assign d_cnt[2] = bus_c.count;
  assign d_tc[0]  = bus_a.tc;     assign d_tc[1]  = bus_b.tc;     assign d_tc[2]  = bus_c.tc;
  assign d_ovf[0] = bus_a.ovf;    assign d_ovf[1] = bus_b.ovf;    assign d_ovf[2] = bus_c.ovf;
  assign d_udf[0] = bus_a.udf;    assign d_udf[1] = bus_b.udf;    assign d_udf[2] = bus_c.udf;
  assign d_mat[0] = bus_a.match;  assign d_mat[1] = bus_b.match;  assign d_mat[2] = bus_c.match;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the counting rules.
  int m_cnt [NI] = '{0, 0, 0};
  bit m_tc  [NI] = '{0, 0, 0};
  bit m_ovf [NI] = '{0, 0, 0};
  bit m_udf [NI] = '{0, 0, 0};

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        m_cnt[i] <= 0;
        m_tc[i]  <= 1'b0;
        m_ovf[i] <= 1'b0;
        m_udf[i] <= 1'b0;
      end else begin : step
        automatic int c   = m_cnt[i];
        automatic bit t   = 1'b0;
        automatic bit ovs = 1'b0;
        automatic bit uds = 1'b0;
        automatic int lv  = int'(bus_a.load_value);
        if (bus_a.load) begin
          c = (lv > MAXS[i]) ? MAXS[i] : lv;
        end else if (bus_a.en) begin
          if (bus_a.up) begin
            if (c == MAXS[i]) begin
              t = 1'b1; ovs = 1'b1; c = SATS[i] ? MAXS[i] : 0;
            end else begin
              c = c + 1;
            end
          end else begin
            if (c == 0) begin
              t = 1'b1; uds = 1'b1; c = SATS[i] ? 0 : MAXS[i];
            end else begin
              c = c - 1;
            end
          end
        end
        m_cnt[i] <= c;
        m_tc[i]  <= t;
        m_ovf[i] <= ovs ? 1'b1 : (bus_a.clr_flags ? 1'b0 : m_ovf[i]);
        m_udf[i] <= uds ? 1'b1 : (bus_a.clr_flags ? 1'b0 : m_udf[i]);
      end
    end
  end

  // Every-cycle comparison on the falling edge.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("cyc_count[%0d]", i), 32'(d_cnt[i]), 32'(m_cnt[i]));
      chk($sformatf("cyc_tc[%0d]", i),    32'(d_tc[i]),  32'(m_tc[i]));
      chk($sformatf("cyc_ovf[%0d]", i),   32'(d_ovf[i]), 32'(m_ovf[i]));
      chk($sformatf("cyc_udf[%0d]", i),   32'(d_udf[i]), 32'(m_udf[i]));
      chk($sformatf("cyc_match[%0d]", i), 32'(d_mat[i]),
          32'(m_cnt[i] == int'(bus_a.cmp_value)));
    end
  end

  // Apply one cycle of inputs to all three counters, then step past the edge.
  task automatic drive(input bit ld, input int lv, input bit en, input bit up,
                       input bit clr, input int cmp);
    bus_a.load = ld;  bus_b.load = ld;  bus_c.load = ld;
    bus_a.load_value = 12'(lv); bus_b.load_value = 12'(lv); bus_c.load_value = 12'(lv);
    bus_a.en = en;    bus_b.en = en;    bus_c.en = en;
    bus_a.up = up;    bus_b.up = up;    bus_c.up = up;
    bus_a.clr_flags = clr; bus_b.clr_flags = clr; bus_c.clr_flags = clr;
    bus_a.cmp_value = 12'(cmp); bus_b.cmp_value = 12'(cmp); bus_c.cmp_value = 12'(cmp);
    @(posedge clk);
    #1;
  endtask

  int exp_b [5] = '{2, 1, 0, 9, 8};
  bit exp_tb [5] = '{0, 0, 0, 1, 0};
  bit exp_tcc [4] = '{0, 1, 1, 1};

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_count_a", 32'(bus_a.count), 0);
    chk("reset_tc_a",    32'(bus_a.tc), 0);
    chk("reset_ovf_a",   32'(bus_a.ovf), 0);
    chk("reset_match_a", 32'(bus_a.match), 1);

    // Full-range up count on the 12-bit instance.
    for (int k = 0; k < 4095; k++) drive(0, 0, 1, 1, 0, 0);
    chk("t1_count_4095", 32'(bus_a.count), 4095);
    chk("t1_tc_before",  32'(bus_a.tc), 0);
    chk("t1_ovf_before", 32'(bus_a.ovf), 0);
    drive(0, 0, 1, 1, 0, 0);
    chk("t1_count_wrap", 32'(bus_a.count), 0);
    chk("t1_tc_wrap",    32'(bus_a.tc), 1);
    chk("t1_ovf_wrap",   32'(bus_a.ovf), 1);
    drive(0, 0, 0, 1, 0, 0);
    chk("t1_tc_after",   32'(bus_a.tc), 0);

    // MAX=9 wrap, counting down through zero.
    drive(0, 0, 0, 0, 1, 0);
    drive(1, 3, 0, 0, 0, 0);
    chk("t2_load3", 32'(bus_b.count), 3);
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, 1, 0, 0, 0);
      chk($sformatf("t2_count_%0d", k), 32'(bus_b.count), 32'(exp_b[k]));
      chk($sformatf("t2_tc_%0d", k), 32'(bus_b.tc), 32'(exp_tb[k]));
    end
    chk("t2_udf", 32'(bus_b.udf), 1);
    chk("t2_ovf", 32'(bus_b.ovf), 0);

    // MAX=9 saturate, counting up into the bound.
    drive(0, 0, 0, 0, 1, 0);
    drive(1, 8, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 1, 1, 0, 0);
      chk($sformatf("t3_count_%0d", k), 32'(bus_c.count), 9);
      chk($sformatf("t3_tc_%0d", k), 32'(bus_c.tc), 32'(exp_tcc[k]));
    end
    chk("t3_ovf_set", 32'(bus_c.ovf), 1);
    drive(0, 0, 0, 1, 1, 0);
    chk("t3_ovf_clr", 32'(bus_c.ovf), 0);

    // Load wins over enable and clamps; set beats clear at the bound.
    drive(1, 12'hFFF, 1, 1, 0, 0);
    chk("t4_clamp_b", 32'(bus_b.count), 9);
    chk("t4_clamp_c", 32'(bus_c.count), 9);
    chk("t4_tc_c",    32'(bus_c.tc), 0);
    chk("t4_full_a",  32'(bus_a.count), 4095);
    drive(0, 0, 1, 1, 1, 0);
    chk("t4_ovf_c_setwins", 32'(bus_c.ovf), 1);
    chk("t4_count_c_hold",  32'(bus_c.count), 9);
    chk("t4_count_b_wrap",  32'(bus_b.count), 0);

    // Asynchronous reset between edges.
    drive(1, 35, 0, 0, 0, 0);
    drive(0, 0, 1, 1, 0, 0);
    drive(0, 0, 1, 1, 0, 0);
    chk("t5_count_37", 32'(bus_a.count), 37);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_async_count", 32'(bus_a.count), 0);
    chk("t5_async_ovf",   32'(bus_a.ovf), 0);
    chk("t5_async_tc",    32'(bus_a.tc), 0);
    chk("t5_async_match", 32'(bus_a.match), 1);
    drive(0, 0, 1, 1, 0, 0);
    rst = 1'b0;
    drive(0, 0, 1, 1, 0, 0);
    chk("t5_resume", 32'(bus_a.count), 1);

    // Compare match and per-cycle direction change.
    drive(1, 0, 0, 0, 0, 5);
    for (int k = 1; k <= 5; k++) begin
      drive(0, 0, 1, 1, 0, 5);
      chk($sformatf("t6_match_%0d", k), 32'(bus_a.match), 32'(k == 5));
    end
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 1, (k % 2) == 0, 0, 5);
      chk($sformatf("t6_alt_%0d", k), 32'(bus_a.count), ((k % 2) == 0) ? 6 : 5);
    end

    // Randomized traffic with occasional reset.
    for (int k = 0; k < 3000; k++) begin
      automatic bit r   = ($urandom_range(0, 199) == 0);
      automatic bit ld  = ($urandom_range(0, 9) == 0);
      automatic int lv  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 4095))
                                                     : int'($urandom_range(0, 12));
      automatic bit en  = ($urandom_range(0, 3) != 0);
      automatic bit up  = 1'($urandom_range(0, 1));
      automatic bit clr = ($urandom_range(0, 15) == 0);
      automatic int cmp = int'($urandom_range(0, 12));
      rst = r;
      drive(ld, lv, en, up, clr, cmp);
    end
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
